// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 100000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 7;
    localparam int DEF_EVT_W         = 8;

    // Width of the shared down-counter so it can hold the largest reload value.
    function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                     input int stable_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, asynchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability stage followed by the output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the system reset. Lock loss or lock timeout restarts the PLL.
// Optional macro PLL_RETRY_LIMIT_EN adds a retry limit and a terminal FAIL state.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PLL_RST   | PLL reset held high for RST_CYCLES cycles; lock not sampled
// WAIT_LOCK | PLL reset released, waiting up to LOCK_TIMEOUT cycles for lock
// STABLE    | lock seen, must hold for STABLE_CYCLES cycles before release
// RUN       | system reset released, ready high
// FAIL      | retry limit exhausted; only sysRst leaves (macro builds only)
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int EVT_W         = DEF_EVT_W
) (
    input  logic             sysClk,
    input  logic             sysRst,
    input  logic             pllLocked,
    output logic             pllRst,
    output logic             rstOut,
    output logic             ready,
    output logic [EVT_W-1:0] lockLossCnt,
    output logic             failed
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LOAD  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LOAD  = CW'(STABLE_CYCLES - 1);

    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_bad_cycles
        $error("cycle parameters must be at least 1");
    end
    if (MAX_RETRIES < 0) begin : g_bad_retries
        $error("MAX_RETRIES must be non-negative");
    end

    pll_state_t    state, state_nxt, loss_dest;
    logic [CW-1:0] cnt, cnt_nxt, cnt_load;
    logic          lock_s;
    logic          loss_evt;
    logic          pll_rst_d, rst_out_d, ready_d;

    sync_2ff u_lock_sync (
        .clk (sysClk),
        .rst (sysRst),
        .d   (pllLocked),
        .q   (lock_s)
    );

    // State and shared down-counter register.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            state <= PLL_RST;
            cnt   <= RST_LOAD;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, loss event and counter reload on every state change.
    always_comb begin
        state_nxt = state;
        loss_evt  = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == '0) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock has priority over a timeout expiring in the same cycle.
                if (lock_s) begin
                    state_nxt = STABLE;
                end else if (cnt == '0) begin
                    loss_evt  = 1'b1;
                    state_nxt = loss_dest;
                end
            end
            STABLE: begin
                if (!lock_s)          state_nxt = WAIT_LOCK;
                else if (cnt == '0)   state_nxt = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    loss_evt  = 1'b1;
                    state_nxt = loss_dest;
                end
            end
            FAIL:    state_nxt = FAIL;
            default: state_nxt = PLL_RST;
        endcase

        case (state_nxt)
            PLL_RST:   cnt_load = RST_LOAD;
            WAIT_LOCK: cnt_load = TO_LOAD;
            STABLE:    cnt_load = ST_LOAD;
            default:   cnt_load = '0;
        endcase

        if (state_nxt != state)  cnt_nxt = cnt_load;
        else if (cnt == '0)      cnt_nxt = cnt;
        else                     cnt_nxt = cnt - CW'(1);
    end

    // Output decode from the next state so the registered outputs track the state.
    always_comb begin
        pll_rst_d = (state_nxt == PLL_RST) || (state_nxt == FAIL);
        rst_out_d = (state_nxt != RUN);
        ready_d   = (state_nxt == RUN);
    end

    // Registered outputs.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            pllRst <= 1'b1;
            rstOut <= 1'b1;
            ready  <= 1'b0;
        end else begin
            pllRst <= pll_rst_d;
            rstOut <= rst_out_d;
            ready  <= ready_d;
        end
    end

    // Saturating lock-loss / timeout event counter.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst)
            lockLossCnt <= '0;
        else if (loss_evt && (lockLossCnt != '1))
            lockLossCnt <= lockLossCnt + EVT_W'(1);
    end

`ifdef PLL_RETRY_LIMIT_EN
    localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

    logic [RW-1:0] retry;
    logic          retry_ovf;

    assign retry_ovf = (retry >= RW'(MAX_RETRIES));
    assign loss_dest = retry_ovf ? FAIL : PLL_RST;

    // Retry count: bumps on each loss event, cleared by reaching RUN.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst)
            retry <= '0;
        else if ((state_nxt == RUN) && (state != RUN))
            retry <= '0;
        else if (loss_evt && !retry_ovf)
            retry <= retry + RW'(1);
    end

    // Registered failure flag.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) failed <= 1'b0;
        else        failed <= (state_nxt == FAIL);
    end
`else
    assign loss_dest = PLL_RST;
    assign failed    = 1'b0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq with shortened timing parameters.
module tb_pll_rst_seq;

    localparam int RC = 4;
    localparam int LT = 50;
    localparam int SC = 8;
    localparam int MR = 2;
    localparam int EW = 4;
    localparam int SAT = (1 << EW) - 1;

    logic          sysClk = 1'b0;
    logic          sysRst = 1'b1;
    logic          pllLocked = 1'b0;
    logic          pllRst, rstOut, ready, failed;
    logic [EW-1:0] lockLossCnt;

    int checks = 0;
    int failures = 0;

    always #5 sysClk = ~sysClk;

    pll_rst_seq #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .EVT_W         (EW)
    ) dut (
        .sysClk      (sysClk),
        .sysRst      (sysRst),
        .pllLocked   (pllLocked),
        .pllRst      (pllRst),
        .rstOut      (rstOut),
        .ready       (ready),
        .lockLossCnt (lockLossCnt),
        .failed      (failed)
    );

    // Behavioural model: phase plus cycles spent in it, lock seen two edges late.
    localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_DEAD = 4;
    int   m_ph, m_age, m_loss, m_retry;
    logic m_p1, m_p2, m_lks;

    task automatic m_lost();
        if (m_loss < SAT) m_loss = m_loss + 1;
        m_age = 0;
`ifdef PLL_RETRY_LIMIT_EN
        if (m_retry == MR) m_ph = PH_DEAD;
        else begin m_retry = m_retry + 1; m_ph = PH_RST; end
`else
        m_ph = PH_RST;
`endif
    endtask

    always @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            m_ph = PH_RST; m_age = 0; m_loss = 0; m_retry = 0;
            m_p1 = 1'b0; m_p2 = 1'b0;
        end else begin
            m_lks = m_p2;
            m_p2  = m_p1;
            m_p1  = pllLocked;
            case (m_ph)
                PH_RST: begin
                    m_age = m_age + 1;
                    if (m_age == RC) begin m_ph = PH_WAIT; m_age = 0; end
                end
                PH_WAIT: begin
                    if (m_lks) begin m_ph = PH_STAB; m_age = 0; end
                    else begin
                        m_age = m_age + 1;
                        if (m_age == LT) m_lost();
                    end
                end
                PH_STAB: begin
                    if (!m_lks) begin m_ph = PH_WAIT; m_age = 0; end
                    else begin
                        m_age = m_age + 1;
                        if (m_age == SC) begin m_ph = PH_RUN; m_age = 0; m_retry = 0; end
                    end
                end
                PH_RUN: begin
                    if (!m_lks) m_lost();
                end
                default: ;
            endcase
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge sysClk) begin
        logic [3:0]    e_flags, a_flags;
        logic [EW-1:0] e_cnt;
        e_flags = {(m_ph == PH_RST) || (m_ph == PH_DEAD), m_ph != PH_RUN,
                   m_ph == PH_RUN, m_ph == PH_DEAD};
        e_cnt   = EW'(m_loss);
        a_flags = {pllRst, rstOut, ready, failed};
        checks  = checks + 1;
        if (a_flags !== e_flags || lockLossCnt !== e_cnt) begin
            failures = failures + 1;
            $display("FAIL model_cycle t=%0t {pllRst,rstOut,ready,failed} got=%b want=%b lockLossCnt got=%0d want=%0d",
                     $time, a_flags, e_flags, lockLossCnt, e_cnt);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return pllRst;
            1:       return rstOut;
            2:       return ready;
            default: return failed;
        endcase
    endfunction

    // Counts edges until the selected output reaches val; -1 if the bound expires.
    task automatic wait_out(input int sel, input logic val, input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc && n < 0; i++) begin
            @(posedge sysClk);
            #1;
            if (pick(sel) === val) n = i;
        end
    endtask

    task automatic do_reset(input logic lock);
        #1 sysRst = 1'b1;
        pllLocked = lock;
        repeat (3) @(posedge sysClk);
        #1 sysRst = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;

        // Reset values
        repeat (5) @(posedge sysClk);
        #1;
        check("reset_flags", int'({pllRst, rstOut, ready, failed}), 4'b1100);
        check("reset_cnt", int'(lockLossCnt), 0);
        sysRst = 1'b0;

        // 1: clean start
        wait_out(0, 1'b0, 20, n);
        check("t1_pllrst_width", n, RC);
        repeat (10) @(posedge sysClk);
        #1 pllLocked = 1'b1;
        wait_out(1, 1'b0, 60, n);
        check("t1_rstout_fall", n + 10, 21);
        check("t1_ready", int'(ready), 1);
        check("t1_cnt", int'(lockLossCnt), 0);

        // 3: one-cycle lock loss in RUN
        pllLocked = 1'b0;
        @(posedge sysClk);
        #1 pllLocked = 1'b1;
        wait_out(1, 1'b1, 20, n);
        check("t3_rstout_rise", n + 1, 3);
        check("t3_pllrst_same_edge", int'(pllRst), 1);
        check("t3_ready_low", int'(ready), 0);
        check("t3_cnt", int'(lockLossCnt), 1);
        wait_out(0, 1'b0, 20, n);
        check("t3_pllrst_width", n, RC);
        wait_out(2, 1'b1, 40, n);
        check("t3_relock", n, SC + 1);

        // 6: asynchronous reset between edges while in RUN
        #2 sysRst = 1'b1;
        #1;
        check("t6_async_flags", int'({pllRst, rstOut, ready}), 3'b110);
        check("t6_async_cnt", int'(lockLossCnt), 0);
        pllLocked = 1'b0;
        repeat (2) @(posedge sysClk);
        #1 sysRst = 1'b0;

        // 4: glitch in STABLE
        wait_out(0, 1'b0, 20, n);
        check("t4_pllrst_width", n, RC);
        pllLocked = 1'b1;
        repeat (5) @(posedge sysClk);
        #1 pllLocked = 1'b0;
        @(posedge sysClk);
        #1 pllLocked = 1'b1;
        wait_out(1, 1'b0, 60, n);
        check("t4_rstout_fall", n, SC + 3);
        check("t4_cnt", int'(lockLossCnt), 0);

        // 7: lock arrives on the timeout edge; lock wins
        do_reset(1'b0);
        wait_out(0, 1'b0, 20, n);
        repeat (LT - 3) @(posedge sysClk);
        #1 pllLocked = 1'b1;
        wait_out(2, 1'b1, 40, n);
        check("t7_lock_wins", n, SC + 3);
        check("t7_cnt", int'(lockLossCnt), 0);

`ifndef PLL_RETRY_LIMIT_EN
        // 2: repeated timeouts, then saturation
        do_reset(1'b0);
        wait_out(0, 1'b0, 20, n);
        check("t2_first_pulse", n, RC);
        for (int k = 1; k <= 3; k++) begin
            wait_out(0, 1'b1, LT + 10, n);
            check("t2_timeout", n, LT);
            wait_out(0, 1'b0, 20, n);
            check("t2_pulse", n, RC);
            check("t2_cnt", int'(lockLossCnt), k);
        end
        for (int k = 4; k <= SAT + 5; k++) begin
            wait_out(0, 1'b1, LT + 10, n);
            wait_out(0, 1'b0, 20, n);
        end
        check("t2_saturate", int'(lockLossCnt), SAT);
`else
        // 5: retry limit
        do_reset(1'b0);
        wait_out(0, 1'b0, 20, n);
        for (int k = 1; k <= MR; k++) begin
            wait_out(0, 1'b1, LT + 10, n);
            check("t5_timeout", n, LT);
            wait_out(0, 1'b0, 20, n);
            check("t5_cnt", int'(lockLossCnt), k);
            check("t5_not_failed", int'(failed), 0);
        end
        wait_out(3, 1'b1, LT + 10, n);
        check("t5_fail_time", n, LT);
        repeat (100) @(posedge sysClk);
        #1;
        check("t5_fail_hold", int'({pllRst, rstOut, ready, failed}), 4'b1101);
        sysRst = 1'b1;
        #1;
        check("t5_clear_failed", int'(failed), 0);
        check("t5_clear_cnt", int'(lockLossCnt), 0);
        repeat (2) @(posedge sysClk);
        #1 sysRst = 1'b0;
`endif

        repeat (3) @(posedge sysClk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
